seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised sequential ALU that succeeds the 4-bit combinational ALU in the TinyTapeout top level. It accepts operands a/b and a 4-bit opcode on a start strobe and returns a registered 2·WIDTH-bit result with status flags and a one-cycle done pulse. Multiply and divide are iterative (one bit per cycle); all other operations complete in one cycle. It is instantiated inside the tt_um top, with ui_in/uio_in feeding the operands and opcode and uo_out showing the result.

## Interface
- WIDTH, 4: operand width, ≥2; result is 2·WIDTH bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock-enable; low freezes all state and outputs.
- start  in  1  request strobe, sampled only in IDLE.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- opcode  in  4  operation select.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle until the next done.
- result  out  2·WIDTH  registered result.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD carry-out, or SUB borrow.
- flag_ovf  out  1  signed overflow on ADD/SUB; MUL high half ≠ 0.
- flag_dz  out  1  divide by zero.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT a, 8 SHL a by b mod WIDTH, 9 SHR a by b mod WIDTH, A CMP. B–F are reserved.
- ADD/SUB: result = zero-extended WIDTH-bit sum or difference; carry and borrow go to flag_carry only.
- Logic and shift ops: result upper WIDTH bits = 0.
- CMP: result[2:0] = {a>b, a==b, a<b}; other bits 0.
- MUL: shift-add over WIDTH cycles; result = a·b (full 2·WIDTH bits).
- DIV: restoring division over WIDTH cycles; result = {remainder, quotient}.
- DIV with b=0: skips RUN; quotient = all ones, remainder = a, flag_dz=1.
- Reserved opcodes: result 0, all flags 0 except flag_zero=1, done still issued.
- flag_zero is computed on the final 2·WIDTH result for all ops. Flags not defined for an op are driven 0.
- FSM states:
  - IDLE: start & ena → latch a, b, opcode. MUL, or DIV with b≠0 → RUN with count=0. Otherwise compute the result → DONE.
  - RUN: one iteration per enabled cycle; when count = WIDTH−1 → DONE.
  - DONE: done=1 for this cycle only; next state IDLE.
- start outside IDLE is ignored; no queueing.
- Operands and opcode are latched at acceptance. Input changes afterwards have no effect.

## Timing
- Reset, asynchronous assert: state=IDLE, busy=0, done=0, result=0, all flags 0.
- Reset mid-RUN aborts the operation with no done.
- Single-cycle ops: start sampled at edge k → done high between edges k+1 and k+2.
- MUL/DIV (b≠0): done follows the accepting edge by WIDTH+1 edges.
- busy rises the cycle after acceptance and falls with the edge that leaves DONE.
- Back-to-back: a start held high is re-accepted in the IDLE cycle after DONE. This gives a minimum issue interval of 2 cycles for single-cycle ops.
- ena=0 stalls FSM, counter and datapath for that cycle. done stays high through a stall in DONE, so its width stretches.
- result and flags hold their last value until the next done.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_CMP);
  - state enum (S_IDLE, S_RUN, S_DONE);
  - a function for the counter width, $clog2(WIDTH).
- Sub-module seq_muldiv holds the iterative shift-add / restoring-divide datapath and counter. It uses a start/last handshake with the parent FSM.
- Single-cycle ops are a combinational case in seq_alu feeding the result register.

## Test plan
- WIDTH=4, ADD a=9, b=9 → done 2 edges after start; result=0x12 → check spec: result=0x02, flag_carry=1, flag_ovf=1 (signed −7 + −7).
- MUL a=15, b=13 → busy for 5 cycles, done 5 edges after acceptance, result=0xC3, flag_ovf=1. Repeat with a=0 → result=0, flag_zero=1.
- DIV a=14, b=3 → result={rem 2, quo 4}=0x24, done at WIDTH+1. DIV a=7, b=0 → result=0x7F, flag_dz=1, done at edge 2.
- start pulsed mid-RUN with new operands → ignored, first result unchanged. Toggle ena low for 3 cycles mid-RUN → done delayed exactly 3 cycles.
- Assert rst_n=0 mid-MUL → outputs 0 immediately, no done. Next start after release works normally.
- WIDTH=8 regression: random 1000 ops against a reference model, including SHL a=0x81, b=9 → 0x02 and CMP a=b → result=0x02.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and
// the iteration-counter width helper used by the multiply/divide unit.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative datapath: shift-add multiply / restoring divide, one bit per
// enabled step. Ports: start loads operands, step iterates, last flags the
// final iteration, result is {hi,lo} product or {remainder,quotient}.
module seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = cnt_w(WIDTH);
    localparam int RW = 2 * WIDTH;

    logic [RW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        // MUL: acc = {partial high, multiplier bits still to consume}
        mul_sum = {1'b0, acc_q[RW-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        // DIV: acc = {partial remainder, dividend bits / quotient bits}
        div_sh   = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (ena) begin
            if (start) begin
                acc_d  = is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                opnd_d = is_div ? b : a;
                div_d  = is_div;
                cnt_d  = '0;
            end else if (step) begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    if (div_diff[WIDTH]) begin
                        acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(WIDTH - 1));
    assign result = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: accepts a/b/opcode on start in IDLE, returns a registered
// 2*WIDTH result with flags and a done pulse. Ports: clk, rst_n, ena, start,
// a, b, opcode in; busy, done, result, flag_zero/carry/ovf/dz out.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         opcode,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               flag_ovf,
    output logic               flag_dz
);

    localparam int RW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] W_B = WIDTH'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [RW-1:0]    result_q, result_d;
    logic             fz_q, fz_d;
    logic             fc_q, fc_d;
    logic             fo_q, fo_d;
    logic             fd_q, fd_d;
    logic             done_q, done_d;

    logic             md_start, md_step, md_last;
    logic [RW-1:0]    md_result;

    logic [WIDTH:0]   add_s, sub_s;
    logic [WIDTH-1:0] shamt;
    logic             launch_md;
    logic [RW-1:0]    res_n;
    logic             c_n, o_n, dz_n;

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .start  (md_start),
        .step   (md_step),
        .is_div (opcode == OP_DIV),
        .a      (a),
        .b      (b),
        .last   (md_last),
        .result (md_result)
    );

    // Result of the latched operation, consumed in DONE.
    always_comb begin
        add_s = {1'b0, a_q} + {1'b0, b_q};
        sub_s = {1'b0, a_q} - {1'b0, b_q};
        shamt = b_q % W_B;
        res_n = '0;
        c_n   = 1'b0;
        o_n   = 1'b0;
        dz_n  = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_n = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
                c_n   = add_s[WIDTH];
                o_n   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                      && (add_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_n = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
                c_n   = sub_s[WIDTH];
                o_n   = (a_q[WIDTH-1] != b_q[WIDTH-1])
                      && (sub_s[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_MUL: begin
                res_n = md_result;
                o_n   = |md_result[RW-1:WIDTH];
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    res_n = {a_q, {WIDTH{1'b1}}};
                    dz_n  = 1'b1;
                end else begin
                    res_n = md_result;
                end
            end
            OP_AND: res_n = {{WIDTH{1'b0}}, a_q & b_q};
            OP_OR:  res_n = {{WIDTH{1'b0}}, a_q | b_q};
            OP_XOR: res_n = {{WIDTH{1'b0}}, a_q ^ b_q};
            OP_NOT: res_n = {{WIDTH{1'b0}}, ~a_q};
            OP_SHL: res_n = {{WIDTH{1'b0}}, a_q << shamt};
            OP_SHR: res_n = {{WIDTH{1'b0}}, a_q >> shamt};
            OP_CMP: res_n = {{(RW-3){1'b0}},
                             a_q > b_q, a_q == b_q, a_q < b_q};
            default: res_n = '0;
        endcase
    end

    assign launch_md = (opcode == OP_MUL)
                     || ((opcode == OP_DIV) && (b != '0));

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        fz_d     = fz_q;
        fc_d     = fc_q;
        fo_d     = fo_q;
        fd_d     = fd_q;
        done_d   = done_q;
        md_start = 1'b0;
        md_step  = 1'b0;
        if (ena) begin
            // done is registered off DONE so it holds through a stall.
            done_d = (state_q == S_DONE);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_d  = a;
                        b_d  = b;
                        op_d = opcode;
                        if (launch_md) begin
                            md_start = 1'b1;
                            state_d  = S_RUN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    md_step = 1'b1;
                    if (md_last) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    result_d = res_n;
                    fz_d     = (res_n == '0);
                    fc_d     = c_n;
                    fo_d     = o_n;
                    fd_d     = dz_n;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            fo_q     <= 1'b0;
            fd_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
            fo_q     <= fo_d;
            fd_q     <= fd_d;
            done_q   <= done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign result     = result_q;
    assign flag_zero  = fz_q;
    assign flag_carry = fc_q;
    assign flag_ovf   = fo_q;
    assign flag_dz    = fd_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed WIDTH=4 steps, then random WIDTH=8 ops
// compared against an arithmetic reference model.
module tb_seq_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       ena4 = 1'b1, start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, op4 = '0;
    logic       busy4, done4, z4, c4, o4, d4;
    logic [7:0] r4;

    logic       ena8 = 1'b1, start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [3:0] op8 = '0;
    logic       busy8, done8, z8, c8, o8, d8;
    logic [15:0] r8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .ena(ena4), .start(start4),
        .a(a4), .b(b4), .opcode(op4), .busy(busy4), .done(done4),
        .result(r4), .flag_zero(z4), .flag_carry(c4),
        .flag_ovf(o4), .flag_dz(d4)
    );

    seq_alu #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .start(start8),
        .a(a8), .b(b8), .opcode(op8), .busy(busy8), .done(done8),
        .result(r8), .flag_zero(z8), .flag_carry(c8),
        .flag_ovf(o8), .flag_dz(d8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res_of(input bit big);
        return big ? {16'h0, r8} : {24'h0, r4};
    endfunction

    function automatic logic [31:0] flags_of(input bit big);
        return big ? {28'h0, z8, c8, o8, d8} : {28'h0, z4, c4, o4, d4};
    endfunction

    function automatic logic done_of(input bit big);
        return big ? done8 : done4;
    endfunction

    // Reference: results straight from the opcode definitions.
    function automatic void model(input int w, input int op, input int a,
                                  input int b, output int res,
                                  output logic [31:0] fl);
        int mask, half, sa, sb, ss;
        logic c, o, d;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        sa = (a >= half) ? a - (1 << w) : a;
        sb = (b >= half) ? b - (1 << w) : b;
        c = 1'b0; o = 1'b0; d = 1'b0; res = 0;
        case (op)
            0: begin
                res = (a + b) & mask; c = (a + b) > mask;
                ss = sa + sb; o = (ss >= half) || (ss < -half);
            end
            1: begin
                res = (a - b) & mask; c = a < b;
                ss = sa - sb; o = (ss >= half) || (ss < -half);
            end
            2: begin res = a * b; o = (res >> w) != 0; end
            3: begin
                if (b == 0) begin res = (a << w) | mask; d = 1'b1; end
                else res = ((a % b) << w) | (a / b);
            end
            4: res = a & b;
            5: res = a | b;
            6: res = a ^ b;
            7: res = (~a) & mask;
            8: res = (a << (b % w)) & mask;
            9: res = a >> (b % w);
            10: res = ((a > b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a < b) ? 1 : 0);
            default: res = 0;
        endcase
        fl = {28'h0, res == 0, c, o, d};
    endfunction

    task automatic issue(input bit big, input int op, input int a, input int b);
        @(negedge clk);
        if (big) begin
            start8 = 1'b1; op8 = 4'(op); a8 = 8'(a); b8 = 8'(b);
        end else begin
            start4 = 1'b1; op4 = 4'(op); a4 = 4'(a); b4 = 4'(b);
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit big, input int budget, output int lat);
        lat = 0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (done_of(big)) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_op(input bit big, input string tag, input int op,
                            input int a, input int b);
        int w, lat, res, exp_lat;
        logic [31:0] fl;
        w = big ? 8 : 4;
        model(w, op, a, b, res, fl);
        exp_lat = (op == 2 || (op == 3 && b != 0)) ? w + 1 : 1;
        issue(big, op, a, b);
        wait_done(big, 20, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, res_of(big), res);
        chk({tag, "_flags"}, flags_of(big), fl);
    endtask

    initial begin
        int lat, seen, op, a, b;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy4}, 0);
        chk("rst_done", {31'h0, done4}, 0);
        chk("rst_res", res_of(0), 0);
        chk("rst_flags", flags_of(0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        check_op(0, "add_9_9", 0, 9, 9);
        chk("add_9_9_exact", res_of(0), 32'h02);

        issue(0, 2, 15, 13);
        chk("mul_busy", {31'h0, busy4}, 1);
        wait_done(0, 20, lat);
        chk("mul_lat", lat, 5);
        chk("mul_res", res_of(0), 32'hC3);
        chk("mul_ovf", {31'h0, o4}, 1);

        check_op(0, "mul_zero", 2, 0, 13);
        check_op(0, "div_14_3", 3, 14, 3);
        chk("div_14_3_exact", res_of(0), 32'h24);
        check_op(0, "div_by_0", 3, 7, 0);
        chk("div_by_0_exact", res_of(0), 32'h7F);
        check_op(0, "reserved", 12, 5, 6);
        check_op(0, "sub_borrow", 1, 3, 5);

        // start while running must be ignored
        issue(0, 2, 15, 13);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; op4 = 4'd0;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        wait_done(0, 20, lat);
        chk("ignore_lat", lat, 2);
        chk("ignore_res", res_of(0), 32'hC3);
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) seen++;
        end
        chk("ignore_no_second", seen, 0);

        // ena stall of 3 cycles mid-RUN
        issue(0, 2, 3, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ena4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ena4 = 1'b1;
        wait_done(0, 20, lat);
        chk("stall_lat", lat + 5, 8);
        chk("stall_res", res_of(0), 15);

        // done stretches while ena is low
        issue(0, 0, 2, 2);
        @(posedge clk);
        #1;
        chk("stretch_done1", {31'h0, done4}, 1);
        @(negedge clk);
        ena4 = 1'b0;
        @(posedge clk);
        #1;
        chk("stretch_done2", {31'h0, done4}, 1);
        @(negedge clk);
        ena4 = 1'b1;
        @(posedge clk);
        #1;
        chk("stretch_done3", {31'h0, done4}, 0);

        // start held high: re-accepted in the IDLE cycle after DONE
        @(negedge clk);
        start4 = 1'b1; op4 = 4'd0; a4 = 4'd1; b4 = 4'd2;
        @(posedge clk);
        #1;
        chk("b2b_busy1", {31'h0, busy4}, 1);
        @(posedge clk);
        #1;
        chk("b2b_done", {30'h0, done4, busy4}, 2);
        @(posedge clk);
        #1;
        chk("b2b_reaccept", {30'h0, done4, busy4}, 1);
        @(negedge clk);
        start4 = 1'b0;
        wait_done(0, 20, lat);
        chk("b2b_lat", lat, 1);
        chk("b2b_res", res_of(0), 3);

        // asynchronous reset mid-MUL
        issue(0, 2, 15, 13);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_res", res_of(0), 0);
        chk("abort_flags", flags_of(0), 0);
        chk("abort_busy", {30'h0, busy4, done4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done4) seen++;
        end
        chk("abort_no_done", seen, 0);
        check_op(0, "after_abort", 0, 3, 4);

        check_op(1, "shl_81_9", 8, 8'h81, 9);
        chk("shl_81_9_exact", res_of(1), 32'h02);
        check_op(1, "cmp_eq", 10, 8'h5A, 8'h5A);
        chk("cmp_eq_exact", res_of(1), 32'h02);

        for (int i = 0; i < 1000; i++) begin
            op = int'($urandom_range(0, 15));
            a  = int'($urandom_range(0, 255));
            b  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            check_op(1, "rnd", op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
